// File: rtl/camera_capture.sv
// Parallel camera capture: registers sensor pins, pairs bytes into RGB565 pixels,
// drops start-up frames and reports per-line / per-frame statistics.
module camera_capture #(
  parameter int unsigned FRAME_SKIP = 0,
  parameter int unsigned CNT_W      = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             href,
  input  logic [7:0]       data_i,
  output logic             vfb_vs_n,
  output logic             vfb_de,
  output logic [15:0]      vfb_data,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] last_line_pix,
  output logic [CNT_W-1:0] last_frame_lines,
  output logic             odd_err
);

  localparam int unsigned   SKIP_W   = 8;
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(FRAME_SKIP);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_SKIP    = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              vs_s1_q, vs_s2_q, href_s1_q, href_s2_q;
  logic [7:0]        data_s1_q;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic              vs_n_q, vs_n_d;
  logic              de_q, de_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  llp_q, llp_d;
  logic [CNT_W-1:0]  lfl_q, lfl_d;
  logic              odd_q, odd_d;

  logic              vs_rise, vs_fall, href_fall, line_end, assemble;
  logic [CNT_W-1:0]  line_inc, pix_inc;

  assign vs_rise   = vs_s1_q & ~vs_s2_q;
  assign vs_fall   = ~vs_s1_q & vs_s2_q;
  assign href_fall = ~href_s1_q & href_s2_q;
  // A frame closing with href still high also closes the line; its pending byte is dropped.
  assign line_end  = href_fall | (vs_fall & href_s1_q);
  assign assemble  = href_s1_q & ~line_end;
  assign line_inc  = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + CNT_W'(1);
  assign pix_inc   = (pix_cnt_q == CNT_MAX) ? pix_cnt_q : pix_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    vs_n_d      = (state_q != ST_ACTIVE);
    de_d        = 1'b0;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    llp_d       = llp_q;
    lfl_d       = lfl_q;
    odd_d       = odd_q;

    case (state_q)
      ST_WAIT_VS: begin
        if (vs_rise) begin
          if (skip_cnt_q != SKIP_MAX) begin
            state_d = ST_SKIP;
          end else begin
            state_d    = ST_ACTIVE;
            line_cnt_d = '0;
            pix_cnt_d  = '0;
            phase_d    = 1'b0;
          end
        end
      end
      ST_SKIP: begin
        if (vs_fall) begin
          state_d = ST_WAIT_VS;
          if (skip_cnt_q != SKIP_MAX) skip_cnt_d = skip_cnt_q + SKIP_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (assemble) begin
          if (!phase_q) begin
            hi_d    = data_s1_q;
            phase_d = 1'b1;
          end else begin
            de_d      = 1'b1;
            data_d    = {hi_q, data_s1_q};
            pix_cnt_d = pix_inc;
            phase_d   = 1'b0;
          end
        end
        if (line_end) begin
          llp_d      = pix_cnt_q;
          line_cnt_d = line_inc;
          pix_cnt_d  = '0;
          if (phase_q) odd_d = 1'b1;
          phase_d    = 1'b0;
        end
        if (vs_fall) begin
          state_d     = ST_WAIT_VS;
          frame_cnt_d = frame_cnt_q + 16'd1;
          lfl_d       = line_end ? line_inc : line_cnt_q;
        end
      end
      default: state_d = ST_WAIT_VS;
    endcase
  end

  // vsync sync copies reset high so a frame already open at release is not seen as a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_VS;
      vs_s1_q     <= 1'b1;
      vs_s2_q     <= 1'b1;
      href_s1_q   <= 1'b0;
      href_s2_q   <= 1'b0;
      data_s1_q   <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      skip_cnt_q  <= '0;
      vs_n_q      <= 1'b1;
      de_q        <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      llp_q       <= '0;
      lfl_q       <= '0;
      odd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_s1_q     <= vsync;
      vs_s2_q     <= vs_s1_q;
      href_s1_q   <= href;
      href_s2_q   <= href_s1_q;
      data_s1_q   <= data_i;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      vs_n_q      <= vs_n_d;
      de_q        <= de_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      llp_q       <= llp_d;
      lfl_q       <= lfl_d;
      odd_q       <= odd_d;
    end
  end

  assign vfb_vs_n         = vs_n_q;
  assign vfb_de           = de_q;
  assign vfb_data         = data_q;
  assign frame_cnt        = frame_cnt_q;
  assign last_line_pix    = llp_q;
  assign last_frame_lines = lfl_q;
  assign odd_err          = odd_q;

endmodule
